// File: rtl/instr_fetch_stage.sv
// rtl/instr_fetch_stage.sv - instruction fetch stage: PC, memory fetch handshake, instruction register
//
// Owns the program counter and fetches one 16-bit instruction word at a time
// from instruction memory over a request/valid handshake. The fetched word is
// held in the instruction register until the control unit consumes it with
// IRWrite. The PC advances or redirects only on that consume.
//
// Ports:
//   CLK            system clock, rising-edge active
//   reset          asynchronous active-low reset
//   memReq         fetch request, high while waiting for memValid
//   memAddr        fetch address, always equal to pc
//   memRdata       instruction word from memory, qualified by memValid
//   memValid       memory response strobe, only honoured while fetching
//   IRWrite        control unit consumes the held instruction
//   PCWriteEnable  control unit requests a PC redirect
//   PCSource       redirect select, 1 = branchTarget
//   branchTarget   redirect address
//   cmpWrite       load compare flags
//   cmpFlags       compare result from the ALU
//   instrValid     instruction register holds an unconsumed instruction
//   instr          instruction register
//   op             opcode field instr[15:12]
//   cmpRst         registered compare result
//   pc             address of the held or in-flight instruction

module instr_fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        CLK,
    input  logic        reset,
    output logic        memReq,
    output logic [15:0] memAddr,
    input  logic [15:0] memRdata,
    input  logic        memValid,
    input  logic        IRWrite,
    input  logic        PCWriteEnable,
    input  logic        PCSource,
    input  logic [15:0] branchTarget,
    input  logic        cmpWrite,
    input  logic [1:0]  cmpFlags,
    output logic        instrValid,
    output logic [15:0] instr,
    output logic [3:0]  op,
    output logic [1:0]  cmpRst,
    output logic [15:0] pc
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state_q,         state_d;
    logic [15:0] pc_q,            pc_d;
    logic [15:0] instr_q,         instr_d;
    logic        instr_valid_q,   instr_valid_d;
    logic [1:0]  cmp_rst_q,       cmp_rst_d;
    logic        redir_pending_q, redir_pending_d;
    logic [15:0] redir_addr_q,    redir_addr_d;
    logic        mem_req_q,       mem_req_d;

    logic redirect;
    logic consume;

    assign redirect = PCWriteEnable && PCSource;
    // IRWrite only means something while an instruction is held.
    assign consume  = IRWrite && (state_q == HOLD);

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        instr_d         = instr_q;
        instr_valid_d   = instr_valid_q;
        cmp_rst_d       = cmp_rst_q;
        redir_pending_d = redir_pending_q;
        redir_addr_d    = redir_addr_q;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (memValid) begin
                    instr_d       = memRdata;
                    instr_valid_d = 1'b1;
                    state_d       = HOLD;
                end
            end
            HOLD: begin
                if (consume) begin
                    instr_valid_d   = 1'b0;
                    state_d         = FETCH;
                    redir_pending_d = 1'b0;
                    // A same-cycle redirect beats a remembered one.
                    if (redirect) begin
                        pc_d = branchTarget;
                    end else if (redir_pending_q) begin
                        pc_d = redir_addr_q;
                    end else begin
                        pc_d = pc_q + 16'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Redirects arriving between consumes are remembered, latest wins;
        // the in-flight fetch is allowed to complete.
        if (redirect && !consume) begin
            redir_pending_d = 1'b1;
            redir_addr_d    = branchTarget;
        end

        if (cmpWrite) begin
            cmp_rst_d = cmpFlags;
        end

        // Request is registered so it is glitch-free and drops at once on reset.
        mem_req_d = (state_d == FETCH);
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            pc_q            <= RESET_PC;
            instr_q         <= 16'h0000;
            instr_valid_q   <= 1'b0;
            cmp_rst_q       <= 2'b00;
            redir_pending_q <= 1'b0;
            redir_addr_q    <= 16'h0000;
            mem_req_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            instr_q         <= instr_d;
            instr_valid_q   <= instr_valid_d;
            cmp_rst_q       <= cmp_rst_d;
            redir_pending_q <= redir_pending_d;
            redir_addr_q    <= redir_addr_d;
            mem_req_q       <= mem_req_d;
        end
    end

    assign memReq     = mem_req_q;
    assign memAddr    = pc_q;
    assign pc         = pc_q;
    assign instr      = instr_q;
    assign op         = instr_q[15:12];
    assign instrValid = instr_valid_q;
    assign cmpRst     = cmp_rst_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// tb/tb_instr_fetch_stage.sv - self-checking bench for instr_fetch_stage

module tb_instr_fetch_stage;

    localparam logic [15:0] RST_PC = 16'h0010;

    logic        CLK = 1'b0;
    logic        reset;
    logic        memReq;
    logic [15:0] memAddr;
    logic [15:0] memRdata;
    logic        memValid;
    logic        IRWrite;
    logic        PCWriteEnable;
    logic        PCSource;
    logic [15:0] branchTarget;
    logic        cmpWrite;
    logic [1:0]  cmpFlags;
    logic        instrValid;
    logic [15:0] instr;
    logic [3:0]  op;
    logic [1:0]  cmpRst;
    logic [15:0] pc;

    always #5 CLK = ~CLK;

    instr_fetch_stage #(.RESET_PC(RST_PC)) dut (
        .CLK           (CLK),
        .reset         (reset),
        .memReq        (memReq),
        .memAddr       (memAddr),
        .memRdata      (memRdata),
        .memValid      (memValid),
        .IRWrite       (IRWrite),
        .PCWriteEnable (PCWriteEnable),
        .PCSource      (PCSource),
        .branchTarget  (branchTarget),
        .cmpWrite      (cmpWrite),
        .cmpFlags      (cmpFlags),
        .instrValid    (instrValid),
        .instr         (instr),
        .op            (op),
        .cmpRst        (cmpRst),
        .pc            (pc)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: "started" = out of reset for at least one edge,
    // "have" = an instruction is held awaiting consumption.
    bit          m_started;
    bit          m_have;
    logic [15:0] m_pc;
    logic [15:0] m_instr;
    bit          m_pend;
    logic [15:0] m_paddr;
    logic [1:0]  m_cmp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void m_reset();
        m_started = 0;
        m_have    = 0;
        m_pc      = RST_PC;
        m_instr   = 16'h0000;
        m_pend    = 0;
        m_paddr   = 16'h0000;
        m_cmp     = 2'b00;
    endfunction

    function automatic void m_step();
        bit redir;
        bit consumed;
        redir    = PCWriteEnable && PCSource;
        consumed = 0;
        if (!m_started) begin
            m_started = 1;
        end else if (!m_have) begin
            if (memValid) begin
                m_instr = memRdata;
                m_have  = 1;
            end
        end else if (IRWrite) begin
            consumed = 1;
            m_have   = 0;
            if (redir)       m_pc = branchTarget;
            else if (m_pend) m_pc = m_paddr;
            else             m_pc = 16'((32'(m_pc) + 1) % 65536);
            m_pend = 0;
        end
        if (redir && !consumed) begin
            m_pend  = 1;
            m_paddr = branchTarget;
        end
        if (cmpWrite) m_cmp = cmpFlags;
    endfunction

    task automatic compare_all();
        logic [15:0] ei;
        ei = m_instr;
        check("memReq",     32'(memReq),     32'(m_started && !m_have));
        check("memAddr",    32'(memAddr),    32'(m_pc));
        check("pc",         32'(pc),         32'(m_pc));
        check("instrValid", 32'(instrValid), 32'(m_have));
        check("instr",      32'(instr),      32'(m_instr));
        check("op",         32'(op),         32'(ei[15:12]));
        check("cmpRst",     32'(cmpRst),     32'(m_cmp));
    endtask

    // One clock: model follows the DUT edge, outputs compared on the falling edge.
    task automatic tick();
        @(posedge CLK);
        if (!reset) m_reset();
        else        m_step();
        @(negedge CLK);
        compare_all();
    endtask

    task automatic clear_inputs();
        memValid      = 0;
        IRWrite       = 0;
        PCWriteEnable = 0;
        PCSource      = 0;
        cmpWrite      = 0;
    endtask

    task automatic deliver(input logic [15:0] word);
        memRdata = word;
        memValid = 1;
        tick();
        memValid = 0;
    endtask

    task automatic consume(input bit redir, input logic [15:0] tgt);
        IRWrite       = 1;
        PCWriteEnable = redir;
        PCSource      = redir;
        branchTarget  = tgt;
        tick();
        clear_inputs();
    endtask

    initial begin
        reset        = 0;
        memRdata     = 16'h0000;
        branchTarget = 16'h0000;
        cmpFlags     = 2'b00;
        clear_inputs();
        m_reset();
        @(negedge CLK);
        compare_all();
        check("rst_memAddr", 32'(memAddr), 32'h0010);
        tick();

        // Release reset; memory answers in the first fetch cycle.
        reset = 1;
        tick();
        check("tp1_req",  32'(memReq),  32'h1);
        check("tp1_addr", 32'(memAddr), 32'h0010);
        deliver(16'hA123);
        check("tp1_valid", 32'(instrValid), 32'h1);
        check("tp1_op",    32'(op),         32'hA);
        consume(0, 16'h0000);
        check("seq_addr1", 32'(memAddr), 32'h0011);

        // Three wait cycles, IRWrite during FETCH ignored.
        IRWrite = 1;
        tick();
        IRWrite = 0;
        tick();
        tick();
        check("wait_req",  32'(memReq),  32'h1);
        check("wait_addr", 32'(memAddr), 32'h0011);
        deliver(16'h1234);
        consume(0, 16'h0000);
        check("seq_addr2", 32'(memAddr), 32'h0012);

        // Redirect on consume, then PCSource=0 is ignored.
        deliver(16'h2000);
        consume(1, 16'h0040);
        check("br_addr", 32'(memAddr), 32'h0040);
        deliver(16'h3000);
        IRWrite = 1; PCWriteEnable = 1; PCSource = 0; branchTarget = 16'h0077;
        tick();
        clear_inputs();
        check("nosrc_addr", 32'(memAddr), 32'h0041);

        // Two pending redirects during FETCH; latest wins.
        PCWriteEnable = 1; PCSource = 1; branchTarget = 16'h0080;
        tick();
        branchTarget = 16'h0090;
        tick();
        clear_inputs();
        deliver(16'h4000);
        consume(0, 16'h0000);
        check("pend_addr", 32'(memAddr), 32'h0090);
        deliver(16'h5000);
        consume(0, 16'h0000);
        check("pend_next", 32'(memAddr), 32'h0091);

        // PC wrap.
        deliver(16'h6000);
        consume(1, 16'hFFFF);
        check("wrap_pre", 32'(memAddr), 32'hFFFF);
        deliver(16'h7000);
        consume(0, 16'h0000);
        check("wrap_addr", 32'(memAddr), 32'h0000);

        // Compare flags during FETCH, then async reset mid-fetch.
        cmpWrite = 1; cmpFlags = 2'b10;
        tick();
        cmpWrite = 0;
        check("cmp_rst", 32'(cmpRst), 32'h2);
        check("cmp_req", 32'(memReq), 32'h1);
        #2 reset = 0;
        #1;
        m_reset();
        check("arst_req", 32'(memReq), 32'h0);
        compare_all();
        memRdata = 16'hBEEF;
        memValid = 1;
        tick();
        memValid = 0;
        check("arst_valid", 32'(instrValid), 32'h0);
        check("arst_cmp",   32'(cmpRst),     32'h0);
        check("arst_pc",    32'(pc),         32'h0010);
        reset = 1;

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            memValid      = ($urandom % 3) == 0;
            memRdata      = 16'($urandom);
            IRWrite       = ($urandom % 3) == 0;
            PCWriteEnable = ($urandom % 4) == 0;
            PCSource      = ($urandom % 2) == 0;
            branchTarget  = ($urandom % 8 == 0) ? 16'hFFFF : 16'($urandom);
            cmpWrite      = ($urandom % 3) == 0;
            cmpFlags      = 2'($urandom);
            if ($urandom % 200 == 0) begin
                #2 reset = 0;
                #1;
                m_reset();
                compare_all();
                tick();
                reset = 1;
            end else begin
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
